// File: rtl/audio_sample_fetch.sv
// rtl/audio_sample_fetch.sv - streams a block of samples from a 1-cycle-latency memory through a small FIFO
module audio_sample_fetch #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      base_addr,
  input  logic [15:0]      length,
  input  logic             loop,
  output logic [15:0]      rdaddress,
  input  logic [width-1:0] q,
  output logic [width-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             done
);

  localparam int aw = $clog2(depth);
  typedef logic [aw-1:0] ptr_t;
  typedef logic [aw:0]   cnt_t;
  localparam cnt_t full_level = cnt_t'(depth);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_next;

  logic [15:0]      addr, last_addr, issued, base_r, length_r;
  logic             loop_r, inflight, zero_done;
  logic [width-1:0] fifo_mem [depth];
  ptr_t             wr_ptr, rd_ptr;
  cnt_t             fifo_count, credit_used;
  logic [15:0]      issued_next;
  logic             pass_end, issue, accept_start, drain_done, push, pop;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_used = fifo_count + cnt_t'(inflight);
  assign issued_next = issued + 16'd1;
  assign pass_end    = (issued_next == length_r);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    accept_start = 1'b0;
    drain_done   = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accept_start = 1'b1;
            if (length != 16'd0) state_next = FETCH;
          end
        end
        FETCH: begin
          if (credit_used < full_level) begin
            issue = 1'b1;
            if (pass_end && !loop_r) state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == '0 && !inflight) begin
            drain_done = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign push = inflight;
  assign pop  = sample_valid && sample_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr       <= '0;
      last_addr  <= '0;
      issued     <= '0;
      base_r     <= '0;
      length_r   <= '0;
      loop_r     <= 1'b0;
      inflight   <= 1'b0;
      zero_done  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      zero_done <= accept_start && (length == 16'd0);
      inflight  <= issue;
      if (accept_start) begin
        base_r   <= base_addr;
        length_r <= length;
        loop_r   <= loop;
        addr     <= base_addr;
        issued   <= '0;
      end
      if (issue) begin
        last_addr <= addr;
        if (pass_end && loop_r) begin
          addr   <= base_r;
          issued <= '0;
        end else begin
          addr   <= addr + 16'd1;
          issued <= issued_next;
        end
      end
      if (stop) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        if (push && !pop)      fifo_count <= fifo_count + cnt_t'(1);
        else if (pop && !push) fifo_count <= fifo_count - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= q;
  end

  // Head is forced to zero while empty so stale entries never leak out after reset/stop.
  assign sample_valid = (fifo_count != '0);
  assign sample_out   = sample_valid ? fifo_mem[rd_ptr] : '0;
  assign rdaddress    = issue ? addr : last_addr;
  assign busy         = (state != IDLE);
  assign done         = zero_done | drain_done;

endmodule
